// File: rtl/multi_cycle_control_fsm_if.sv
// Control bus between the multi-cycle FSM and the RV32I datapath.
// Master side is the FSM: it takes decode/status inputs and drives every enable/select.
// Slave side is the datapath (or a bench standing in for it).
interface multi_cycle_control_fsm_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       halt_req;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ALU_op_sig;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       is_halted;

  modport master (
    input  opcode, bcond, halt_req,
    output pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
           alu_src_a, alu_src_b, ALU_op_sig, reg_write, wb_sel, is_halted
  );

  modport slave (
    output opcode, bcond, halt_req,
    input  pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
           alu_src_a, alu_src_b, ALU_op_sig, reg_write, wb_sel, is_halted
  );
endinterface

// File: rtl/multi_cycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB, sticky HALT on ecall-halt.
// Latency: outputs are combinational from state/opcode/bcond/wait counter; IF and MEM last MEM_WAIT cycles each.
// Backpressure: none; memory is assumed to answer in exactly MEM_WAIT cycles, the down-counter paces IF/MEM.
module multi_cycle_control_fsm #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  multi_cycle_control_fsm_if.master    bus
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam int unsigned CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_WAIT - 1);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halted_q, halted_d;

  logic       last;
  logic       is_load, is_store, is_branch, is_jump_reg, is_exec;
  logic       pc_write_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
  logic       alu_src_a_c, alu_op_c, reg_write_c;
  logic [1:0] pc_src_c, alu_src_b_c, wb_sel_c;

  assign last        = (cnt_q == '0);
  assign is_load     = (bus.opcode == OP_LOAD);
  assign is_store    = (bus.opcode == OP_STORE);
  assign is_branch   = (bus.opcode == OP_BRANCH);
  assign is_jump_reg = (bus.opcode == OP_JALR);
  // Opcodes that need an EX cycle; JAL goes straight to WB since ID already computed PC+imm.
  assign is_exec     = (bus.opcode == OP_ARITH) || (bus.opcode == OP_ARITH_IMM) ||
                       is_load || is_store || is_branch || is_jump_reg;

  // State, wait counter and sticky halt flag; reset aborts any instruction back to IF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IF;
      cnt_q    <= CNT_INIT;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  // Next-state and control decode; every output defaults to 0 and is raised per state.
  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    pc_src_c    = 2'b00;
    i_or_d_c    = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    alu_src_a_c = 1'b0;
    alu_src_b_c = 2'b00;
    alu_op_c    = 1'b0;
    reg_write_c = 1'b0;
    wb_sel_c    = 2'b00;

    case (state_q)
      S_IF: begin
        mem_read_c = 1'b1;
        if (last) begin
          ir_write_c = 1'b1;
          state_d    = S_ID;
        end
      end
      S_ID: begin
        // ALUOut <= PC + imm, used later as branch/JAL target.
        alu_src_b_c = 2'b10;
        if ((bus.opcode == OP_ECALL) && bus.halt_req) begin
          state_d = S_HALT;
        end else if (bus.opcode == OP_JAL) begin
          state_d = S_WB;
        end else if (is_exec) begin
          state_d = S_EX;
        end else begin
          // Plain ecall and unknown opcodes retire here as a no-op.
          pc_write_c = 1'b1;
          state_d    = S_IF;
        end
      end
      S_EX: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 1'b1;
        alu_src_b_c = ((bus.opcode == OP_ARITH) || is_branch) ? 2'b00 : 2'b10;
        if (is_branch) begin
          pc_write_c = 1'b1;
          pc_src_c   = bus.bcond ? 2'b01 : 2'b00;
          state_d    = S_IF;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        i_or_d_c = 1'b1;
        if (is_load) begin
          mem_read_c = 1'b1;
          if (last) begin
            ir_write_c = 1'b1;
            state_d    = S_WB;
          end
        end else if (last) begin
          mem_write_c = is_store;
          pc_write_c  = 1'b1;
          state_d     = S_IF;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        if (is_load) begin
          wb_sel_c = 2'b01;
        end else if ((bus.opcode == OP_JAL) || is_jump_reg) begin
          wb_sel_c = 2'b10;
          pc_src_c = 2'b01;
        end
        state_d = S_IF;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IF;
      end
    endcase

    // Counter runs down only inside a memory phase; everywhere else it sits preloaded
    // so the first cycle of the next IF/MEM starts from MEM_WAIT-1.
    if (((state_q == S_IF) || (state_q == S_MEM)) && !last) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = CNT_INIT;
    end

    halted_d = halted_q | (state_d == S_HALT);
  end

  // Write strobes are gated by reset so nothing is written while reset_n is held low.
  assign bus.pc_write   = pc_write_c  & reset_n;
  assign bus.ir_write   = ir_write_c  & reset_n;
  assign bus.mem_write  = mem_write_c & reset_n;
  assign bus.reg_write  = reg_write_c & reset_n;
  assign bus.pc_src     = pc_src_c;
  assign bus.i_or_d     = i_or_d_c;
  assign bus.mem_read   = mem_read_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.ALU_op_sig = alu_op_c;
  assign bus.wb_sel     = wb_sel_c;
  assign bus.is_halted  = halted_q;

endmodule

// File: doc/multi_cycle_control_fsm.md
Name: multi_cycle_control_fsm

Overview:
Main control state machine of the multi-cycle RV32I core. It sequences each instruction through IF/ID/EX/MEM/WB and drives every datapath enable and mux select. It also drives the 1-bit ALU_op_sig consumed by the downstream ALU control unit: 0 forces ADD, 1 decodes from the instruction. It holds a sticky halt on ecall-halt.

Parameters:
MEM_WAIT, 1, cycles spent in IF and in MEM per memory access (>=1); a down-counter implements it.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
opcode  input  7  IR[6:0]; meaningful from ID onward
bcond  input  1  branch-taken flag from ALU, valid in EX
halt_req  input  1  ecall with x17==10, computed externally, valid in ID
pc_write  output  1  PC register load enable
pc_src  output  2  00 PC+4 (dedicated adder), 01 ALUOut, others reserved (drive 00)
i_or_d  output  1  memory address: 0 PC, 1 ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR/MDR load enable
alu_src_a  output  1  0 PC, 1 rs1
alu_src_b  output  2  00 rs2, 01 const 4, 10 imm
ALU_op_sig  output  1  0 force ADD, 1 instruction-decoded op
reg_write  output  1  register file write enable
wb_sel  output  2  00 ALUOut, 01 MDR, 10 PC+4
is_halted  output  1  sticky halt flag

Behaviour:
- State register (3-bit) holds IF, ID, EX, MEM, WB or HALT. A wait counter sized for MEM_WAIT runs alongside it.
- Outputs are decoded combinationally from state, opcode, bcond and the counter. Any output not listed for a state is 0.
- Reset (reset_n low, asynchronous): state=IF, counter=MEM_WAIT-1, is_halted=0. While reset_n is low, pc_write, ir_write, mem_write and reg_write are forced to 0.
- Wait counter:
  - Loads MEM_WAIT-1 on entry to IF or MEM.
  - Decrements each cycle while in IF or MEM.
  - "last" means counter==0. IF and MEM exit only on the last cycle.
- IF:
  - mem_read=1, i_or_d=0.
  - ir_write=1 on the last cycle only, then go to ID.
- ID: alu_src_a=0, alu_src_b=10, ALU_op_sig=0, so ALUOut=PC+imm. Next state by opcode:
  - halt_req=1 (ECALL): go to HALT. pc_write=0.
  - ECALL without halt_req: pc_write=1, pc_src=00, go to IF.
  - JAL: go to WB.
  - ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JALR: go to EX.
  - Any other opcode (NOP skip): pc_write=1, pc_src=00, go to IF.
- EX:
  - alu_src_a=1, ALU_op_sig=1.
  - alu_src_b=00 for ARITHMETIC and BRANCH, 10 otherwise.
  - BRANCH: pc_write=1, pc_src = bcond ? 01 : 00, go to IF. bcond is sampled only in this state.
  - LOAD or STORE: go to MEM.
  - Otherwise: go to WB.
- MEM:
  - i_or_d=1.
  - LOAD: mem_read=1 for all cycles. ir_write=1 on the last cycle (loads MDR). Go to WB.
  - STORE: mem_write=1 on the last cycle only. On that cycle also pc_write=1, pc_src=00, go to IF.
- WB:
  - reg_write=1, pc_write=1, go to IF.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc_src: 01 for JAL/JALR, 00 otherwise.
  - JALR target LSB clearing is done in the datapath.
- HALT:
  - is_halted=1. All strobes 0. State holds until reset.
  - is_halted is registered: it rises the cycle after the ID cycle with halt_req.
- Exactly one pc_write pulse per retired instruction. None for the halting ecall.
- Cycle counts per instruction with MEM_WAIT=1: R/I-type 4, LOAD 5, STORE 4, BRANCH 3, JAL 3, JALR 4. IF and MEM each add MEM_WAIT-1.
- Reset asserted mid-instruction: the FSM aborts immediately to IF. No write strobe is seen after the reset edge.

Test Plan:
- MEM_WAIT=1, R-type add (opcode 0110011) -> states IF,ID,EX,WB. ALU_op_sig 0 in ID and 1 in EX. reg_write=1, wb_sel=00, pc_write=1 only in cycle 4.
- LOAD (0000011) with MEM_WAIT=3 -> IF 3 cycles with ir_write only on the 3rd. MEM 3 cycles with mem_read=1 and i_or_d=1. WB asserts wb_sel=01. 9 cycles total.
- BRANCH (1100011): bcond=1 -> EX cycle has pc_write=1, pc_src=01. bcond=0 -> pc_src=00. Both take 3 cycles and never assert reg_write.
- JAL (1101111) -> IF,ID,WB with wb_sel=10, pc_src=01, reg_write=1. STORE (0100011) -> mem_write=1 exactly one cycle, no reg_write.
- ECALL (1110011) with halt_req=1 -> HALT; is_halted=1 from the next cycle and stays high for 20 cycles. No pc_write. reset_n low clears it.
- reset_n pulsed low during MEM of a STORE -> mem_write never asserts. After release: IF, is_halted=0. Unknown opcode 0000000 -> IF,ID then pc_write with pc_src=00.
